cpu6_csr_m: RTL and testbench
=============================

Name: cpu6_csr_m

Overview:
Parametrised machine-mode CSR file for the cpu6 core, successor to the single-mepc/mie/mip CSR block.
- Adds mstatus (MIE/MPIE), writable mtvec with direct/vectored mode, mscratch, mcause, and 64-bit mcycle/minstret counters.
- Supports three interrupt sources (software, timer, external) with a prioritised interrupt request, plus hardware trap-entry and mret sequencing.
- Sits beside the decode/exception unit: CSR instructions arrive from execute, and trap/mret strobes arrive from the commit stage.

Parameters:
XLEN, 32, data width of all CSRs except counters (counters are always 64 bits, split into lo/hi halves).
MTVEC_RESET, 32'h0000_0000, reset value of mtvec; bits [1:0] select mode.
HART_ID, 0, value returned by mhartid.
HAS_COUNTERS, 1, when 0, mcycle/minstret read 0 and their writes are ignored (access remains legal).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
csr_rd_en  in  1  CSR read strobe
csr_wr_en  in  1  CSR write strobe
csr_op  in  2  01 = write, 10 = set, 11 = clear; 00 = no modification
csr_idx  in  12  CSR address
csr_write_dat  in  XLEN  write operand / mask
csr_read_dat  out  XLEN  combinational read data (current value, before any update)
csr_illegal  out  1  access to an unimplemented CSR, or a write to a read-only CSR
irq_sw, irq_tmr, irq_ext  in  1 each  raw interrupt levels
excp_ena  in  1  trap entry strobe (exception or taken interrupt)
excp_mepc  in  XLEN  PC to save
excp_cause  in  XLEN  cause to save; bit XLEN-1 = interrupt
mret_ena  in  1  mret commit strobe
instret_ena  in  1  instruction retired this cycle
irq_req  out  1  interrupt pending, enabled and globally enabled
irq_cause  out  XLEN  cause for irq_req
trap_pc  out  XLEN  trap target for excp_cause
csr_mepc  out  XLEN  current mepc
csr_mtvec  out  XLEN  current mtvec

Behaviour:
- CSR map:
  - mstatus 0x300: MIE bit 3, MPIE bit 7, MPP [12:11] read as 2'b11; all other bits 0.
  - mie 0x304: MSIE bit 3, MTIE bit 7, MEIE bit 11.
  - mtvec 0x305; mscratch 0x340; mepc 0x341; mcause 0x342.
  - mip 0x344 (read-only, writes flag csr_illegal).
  - mcycle 0xB00 / mcycleh 0xB80; minstret 0xB02 / minstreth 0xB82.
  - mhartid 0xF14 (read-only).
- Reset values: all CSRs 0, except mtvec = MTVEC_RESET and MPP.
  - All outputs are derived from registers, so after reset: irq_req = 0 and csr_mepc = 0.
- Write value: for op 01 it is dat; for op 10 it is old | dat; for op 11 it is old & ~dat. Op 00 never writes.
  - Writes occur at the clock edge when csr_wr_en = 1, the index is legal, and the CSR is writable.
  - An illegal access changes no state.
- Field masking on writes:
  - mepc bit 0 is forced to 0.
  - mtvec mode value 1x is stored as 00.
  - Unimplemented bits of mstatus and mie stay 0.
- mip: each pending bit is a one-cycle registered copy of its irq_* input, so the interrupt is visible the cycle after the input is asserted.
- irq_req = mstatus.MIE & |(mip & mie), combinational from registers.
- irq_cause priority: external (11) > software (3) > timer (7). Format is {1'b1, code}.
- trap_pc:
  - If mtvec mode = 01 and excp_cause[XLEN-1] = 1: {mtvec[XLEN-1:2], 2'b00} + 4 × excp_cause[3:0].
  - Otherwise: {mtvec[XLEN-1:2], 2'b00}.
- Trap entry (excp_ena): mepc <= excp_mepc & ~1; mcause <= excp_cause; MPIE <= MIE; MIE <= 0.
- mret (mret_ena): MIE <= MPIE; MPIE <= 1.
- Simultaneous-event priority:
  - excp_ena > mret_ena > CSR write for mstatus, mepc and mcause.
  - A lower-priority update to those CSRs in the same cycle is dropped.
  - CSR writes to other CSRs proceed normally.
- Counters:
  - mcycle increments by 1 every cycle; minstret increments when instret_ena = 1.
  - A write to the lo half loads lo and holds hi for that cycle (no carry propagated).
  - A write to the hi half loads hi while lo still increments; a carry out of lo that cycle is discarded.
  - Both wrap silently at 2^64 − 1 → 0.
- Reset asserted mid-operation overrides every strobe in that cycle.

Decomposition:
- Shared defines (`CPU6_` prefix):
  - CSR addresses, mstatus/mie bit positions, interrupt cause codes (3/7/11), csr_op encodings, mtvec mode encodings.
- Sub-module cpu6_csr_cnt64: 64-bit counter with inc, wr_lo, wr_hi and write data inputs. It is instantiated twice (mcycle, minstret) and gated by HAS_COUNTERS.

Test Plan:
- Reset, then read mtvec/mstatus/mhartid → MTVEC_RESET, 0x0000_1800, HART_ID; csr_illegal = 0. Read 0x7C0 → csr_illegal = 1, data 0.
- Set mie = 0x80 and mstatus.MIE; assert irq_tmr at cycle N → irq_req = 1 at N+1 with irq_cause = 0x8000_0007. Adding irq_ext → cause 0x8000_000B.
- mtvec = 0x0000_1001 (vectored), excp_cause = 0x8000_0007, excp_mepc = 0x2003 → trap_pc = 0x101C; after the edge: mepc = 0x2002, MIE = 0, MPIE = 1. Then mret_ena → MIE = 1, MPIE = 1.
- Same cycle: excp_ena together with a csrrw to mepc of 0x4000 → mepc = excp_mepc. Set op 0x8 then clear op 0x8 on mstatus → MIE toggles 1 then 0.
- Write mcycle = 0xFFFF_FFFF, then run 2 cycles → mcycleh = 1, mcycle = 1. A minstret write plus instret_ena in the same cycle → the written value is held.
- Write 0x88 to mip → csr_illegal = 1 and mip unchanged; assert reset while excp_ena = 1 → mepc = 0.

Source files
------------

// File: rtl/cpu6_csr_m_pkg.sv
// cpu6 machine-mode CSR file: addresses, field positions,
// interrupt codes and operation encodings.
package cpu6_csr_m_pkg;

    localparam logic [11:0] CPU6_CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CPU6_CSR_MIE      = 12'h304;
    localparam logic [11:0] CPU6_CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CPU6_CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CPU6_CSR_MEPC     = 12'h341;
    localparam logic [11:0] CPU6_CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CPU6_CSR_MIP      = 12'h344;
    localparam logic [11:0] CPU6_CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CPU6_CSR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] CPU6_CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CPU6_CSR_MINSTRH  = 12'hB82;
    localparam logic [11:0] CPU6_CSR_MHARTID  = 12'hF14;

    localparam int CPU6_MSTATUS_MIE  = 3;
    localparam int CPU6_MSTATUS_MPIE = 7;
    localparam int CPU6_MSTATUS_MPPL = 11;
    localparam int CPU6_MSTATUS_MPPH = 12;

    localparam int CPU6_MIE_MSIE = 3;
    localparam int CPU6_MIE_MTIE = 7;
    localparam int CPU6_MIE_MEIE = 11;

    localparam logic [3:0] CPU6_IRQ_SW  = 4'd3;
    localparam logic [3:0] CPU6_IRQ_TMR = 4'd7;
    localparam logic [3:0] CPU6_IRQ_EXT = 4'd11;

    typedef enum logic [1:0] {
        CPU6_OP_NONE  = 2'b00,
        CPU6_OP_WRITE = 2'b01,
        CPU6_OP_SET   = 2'b10,
        CPU6_OP_CLEAR = 2'b11
    } csr_op_e;

    localparam logic [1:0] CPU6_MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] CPU6_MTVEC_VECTORED = 2'b01;

endpackage

// File: rtl/cpu6_csr_m_cnt64.sv
// 64-bit counter as two 32-bit halves; a half write suppresses
// the carry between halves for that cycle.
module cpu6_csr_cnt64 (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdat_i,
    output logic [63:0] cnt_o
);

    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic [32:0] lo_sum;

    always_comb begin
        lo_sum = {1'b0, lo_q} + 33'(inc_i);
        lo_d   = lo_sum[31:0];
        hi_d   = hi_q + 32'(lo_sum[32]);
        if (wr_lo_i) begin
            lo_d = wdat_i;
            hi_d = hi_q;
        end else if (wr_hi_i) begin
            hi_d = wdat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign cnt_o = {hi_q, lo_q};

endmodule

// File: rtl/cpu6_csr_m.sv
// cpu6 machine-mode CSR file with trap entry, mret sequencing,
// prioritised interrupt request and 64-bit counters.
module cpu6_csr_m
    import cpu6_csr_m_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET  = '0,
    parameter int              HART_ID      = 0,
    parameter bit              HAS_COUNTERS = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            csr_rd_en,
    input  logic            csr_wr_en,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_idx,
    input  logic [XLEN-1:0] csr_write_dat,
    output logic [XLEN-1:0] csr_read_dat,
    output logic            csr_illegal,
    input  logic            irq_sw,
    input  logic            irq_tmr,
    input  logic            irq_ext,
    input  logic            excp_ena,
    input  logic [XLEN-1:0] excp_mepc,
    input  logic [XLEN-1:0] excp_cause,
    input  logic            mret_ena,
    input  logic            instret_ena,
    output logic            irq_req,
    output logic [XLEN-1:0] irq_cause,
    output logic [XLEN-1:0] trap_pc,
    output logic [XLEN-1:0] csr_mepc,
    output logic [XLEN-1:0] csr_mtvec
);

    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;
    logic [2:0]      ien_q, ien_d;
    logic [2:0]      ip_q;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [63:0]     cyc, ins;
    logic            legal, ro, modify, wr;
    logic [XLEN-1:0] rdata, wval;
    logic [XLEN-1:0] mstatus_r, mie_r, mip_r;
    logic [XLEN-1:0] base;
    logic [2:0]      pend;
    logic [3:0]      code;

    // ien/ip bit order is {ext, tmr, sw}
    always_comb begin
        mstatus_r = '0;
        mstatus_r[CPU6_MSTATUS_MPPH:CPU6_MSTATUS_MPPL] = 2'b11;
        mstatus_r[CPU6_MSTATUS_MPIE] = mpie_q;
        mstatus_r[CPU6_MSTATUS_MIE]  = mie_q;
        mie_r = '0;
        mie_r[CPU6_MIE_MSIE] = ien_q[0];
        mie_r[CPU6_MIE_MTIE] = ien_q[1];
        mie_r[CPU6_MIE_MEIE] = ien_q[2];
        mip_r = '0;
        mip_r[CPU6_MIE_MSIE] = ip_q[0];
        mip_r[CPU6_MIE_MTIE] = ip_q[1];
        mip_r[CPU6_MIE_MEIE] = ip_q[2];
    end

    always_comb begin
        rdata = '0;
        legal = 1'b1;
        ro    = 1'b0;
        unique case (csr_idx)
            CPU6_CSR_MSTATUS:  rdata = mstatus_r;
            CPU6_CSR_MIE:      rdata = mie_r;
            CPU6_CSR_MTVEC:    rdata = mtvec_q;
            CPU6_CSR_MSCRATCH: rdata = mscratch_q;
            CPU6_CSR_MEPC:     rdata = mepc_q;
            CPU6_CSR_MCAUSE:   rdata = mcause_q;
            CPU6_CSR_MIP: begin
                rdata = mip_r;
                ro    = 1'b1;
            end
            CPU6_CSR_MCYCLE:   rdata = XLEN'(cyc[31:0]);
            CPU6_CSR_MCYCLEH:  rdata = XLEN'(cyc[63:32]);
            CPU6_CSR_MINSTRET: rdata = XLEN'(ins[31:0]);
            CPU6_CSR_MINSTRH:  rdata = XLEN'(ins[63:32]);
            CPU6_CSR_MHARTID: begin
                rdata = XLEN'(HART_ID);
                ro    = 1'b1;
            end
            default:           legal = 1'b0;
        endcase
    end

    always_comb begin
        unique case (csr_op)
            CPU6_OP_WRITE: wval = csr_write_dat;
            CPU6_OP_SET:   wval = rdata | csr_write_dat;
            CPU6_OP_CLEAR: wval = rdata & ~csr_write_dat;
            default:       wval = rdata;
        endcase
    end

    assign modify = csr_wr_en & (csr_op != CPU6_OP_NONE);
    assign wr     = modify & legal & ~ro;
    assign csr_illegal = ((csr_rd_en | csr_wr_en) & ~legal)
                       | (modify & ro);

    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        ien_d      = ien_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        if (wr && csr_idx == CPU6_CSR_MIE)
            ien_d = {wval[CPU6_MIE_MEIE], wval[CPU6_MIE_MTIE],
                     wval[CPU6_MIE_MSIE]};
        if (wr && csr_idx == CPU6_CSR_MTVEC)
            mtvec_d = wval[1] ? {wval[XLEN-1:2], 2'b00} : wval;
        if (wr && csr_idx == CPU6_CSR_MSCRATCH)
            mscratch_d = wval;
        // trap entry wins over mret, which wins over CSR writes
        if (excp_ena) begin
            mepc_d   = {excp_mepc[XLEN-1:1], 1'b0};
            mcause_d = excp_cause;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else begin
            if (wr && csr_idx == CPU6_CSR_MEPC)
                mepc_d = {wval[XLEN-1:1], 1'b0};
            if (wr && csr_idx == CPU6_CSR_MCAUSE)
                mcause_d = wval;
            if (mret_ena) begin
                mie_d  = mpie_q;
                mpie_d = 1'b1;
            end else if (wr && csr_idx == CPU6_CSR_MSTATUS) begin
                mie_d  = wval[CPU6_MSTATUS_MIE];
                mpie_d = wval[CPU6_MSTATUS_MPIE];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            ien_q      <= '0;
            ip_q       <= '0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            ien_q      <= ien_d;
            ip_q       <= {irq_ext, irq_tmr, irq_sw};
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

    generate
        if (HAS_COUNTERS) begin : g_cnt
            cpu6_csr_cnt64 u_mcycle (
                .clk     (clk),
                .reset   (reset),
                .inc_i   (1'b1),
                .wr_lo_i (wr && csr_idx == CPU6_CSR_MCYCLE),
                .wr_hi_i (wr && csr_idx == CPU6_CSR_MCYCLEH),
                .wdat_i  (wval[31:0]),
                .cnt_o   (cyc)
            );
            cpu6_csr_cnt64 u_minstret (
                .clk     (clk),
                .reset   (reset),
                .inc_i   (instret_ena),
                .wr_lo_i (wr && csr_idx == CPU6_CSR_MINSTRET),
                .wr_hi_i (wr && csr_idx == CPU6_CSR_MINSTRH),
                .wdat_i  (wval[31:0]),
                .cnt_o   (ins)
            );
        end else begin : g_nocnt
            assign cyc = '0;
            assign ins = '0;
        end
    endgenerate

    assign pend    = ip_q & ien_q;
    assign irq_req = mie_q & |pend;

    // external beats software beats timer
    always_comb begin
        code      = '0;
        irq_cause = '0;
        priority case (1'b1)
            pend[2]: code = CPU6_IRQ_EXT;
            pend[0]: code = CPU6_IRQ_SW;
            pend[1]: code = CPU6_IRQ_TMR;
            default: code = '0;
        endcase
        if (|pend) begin
            irq_cause[XLEN-1] = 1'b1;
            irq_cause[3:0]    = code;
        end
    end

    always_comb begin
        base    = {mtvec_q[XLEN-1:2], 2'b00};
        trap_pc = base;
        if (mtvec_q[1:0] == CPU6_MTVEC_VECTORED && excp_cause[XLEN-1])
            trap_pc = base + XLEN'({excp_cause[3:0], 2'b00});
    end

    assign csr_read_dat = rdata;
    assign csr_mepc     = mepc_q;
    assign csr_mtvec    = mtvec_q;

endmodule

// File: tb/tb_cpu6_csr_m.sv
// Bench for cpu6_csr_m: directed scenarios, then random traffic
// compared against a CSR-level reference model.
module tb_cpu6_csr_m;

    localparam logic [31:0] TVEC_RST = 32'h0000_0100;
    localparam int          HID      = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        csr_rd_en, csr_wr_en;
    logic [1:0]  csr_op;
    logic [11:0] csr_idx;
    logic [31:0] csr_write_dat, csr_read_dat;
    logic        csr_illegal;
    logic        irq_sw, irq_tmr, irq_ext;
    logic        excp_ena, mret_ena, instret_ena;
    logic [31:0] excp_mepc, excp_cause;
    logic        irq_req;
    logic [31:0] irq_cause, trap_pc, csr_mepc, csr_mtvec;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          m_mie, m_mpie;
    logic [31:0] m_ie, m_ip, m_tvec, m_scr, m_epc, m_cause;
    logic [63:0] m_cyc, m_ins;

    logic [11:0] idx_tab [14] = '{12'h300, 12'h304, 12'h305,
        12'h340, 12'h341, 12'h342, 12'h344, 12'hB00, 12'hB80,
        12'hB02, 12'hB82, 12'hF14, 12'h7C0, 12'h001};

    always #5 clk = ~clk;

    cpu6_csr_m #(
        .XLEN(32), .MTVEC_RESET(TVEC_RST),
        .HART_ID(HID), .HAS_COUNTERS(1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .csr_rd_en(csr_rd_en), .csr_wr_en(csr_wr_en),
        .csr_op(csr_op), .csr_idx(csr_idx),
        .csr_write_dat(csr_write_dat),
        .csr_read_dat(csr_read_dat),
        .csr_illegal(csr_illegal),
        .irq_sw(irq_sw), .irq_tmr(irq_tmr), .irq_ext(irq_ext),
        .excp_ena(excp_ena), .excp_mepc(excp_mepc),
        .excp_cause(excp_cause), .mret_ena(mret_ena),
        .instret_ena(instret_ena), .irq_req(irq_req),
        .irq_cause(irq_cause), .trap_pc(trap_pc),
        .csr_mepc(csr_mepc), .csr_mtvec(csr_mtvec)
    );

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_legal(logic [11:0] a);
        foreach (idx_tab[i])
            if (i < 12 && idx_tab[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_ro(logic [11:0] a);
        return a == 12'h344 || a == 12'hF14;
    endfunction

    function automatic logic [31:0] m_read(logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 | (32'(m_mpie) << 7)
                          | (32'(m_mie) << 3);
            12'h304: return m_ie;
            12'h305: return m_tvec;
            12'h340: return m_scr;
            12'h341: return m_epc;
            12'h342: return m_cause;
            12'h344: return m_ip;
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_ins[31:0];
            12'hB82: return m_ins[63:32];
            12'hF14: return 32'(HID);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_pend();
        return m_ip & m_ie;
    endfunction

    function automatic logic [31:0] m_irq_cause();
        logic [31:0] p = m_pend();
        if (p[11]) return 32'h8000_000B;
        if (p[3])  return 32'h8000_0003;
        if (p[7])  return 32'h8000_0007;
        return 32'h0;
    endfunction

    function automatic logic [31:0] m_trap();
        logic [31:0] b = m_tvec & ~32'h3;
        if (m_tvec[1:0] == 2'b01 && excp_cause[31])
            return b + 32'd4 * 32'(excp_cause[3:0]);
        return b;
    endfunction

    task automatic m_edge();
        logic [31:0] old, wv;
        logic [63:0] ncyc, nins;
        bit doit;
        if (reset) begin
            m_mie = 0; m_mpie = 0; m_ie = 0; m_ip = 0;
            m_tvec = TVEC_RST; m_scr = 0; m_epc = 0;
            m_cause = 0; m_cyc = 0; m_ins = 0;
            return;
        end
        old = m_read(csr_idx);
        case (csr_op)
            2'd1:    wv = csr_write_dat;
            2'd2:    wv = old | csr_write_dat;
            2'd3:    wv = old & ~csr_write_dat;
            default: wv = old;
        endcase
        doit = csr_wr_en && csr_op != 2'd0 && m_legal(csr_idx)
            && !m_ro(csr_idx);
        if (doit && csr_idx == 12'hB00)
            ncyc = {m_cyc[63:32], wv};
        else if (doit && csr_idx == 12'hB80)
            ncyc = {wv, m_cyc[31:0] + 32'd1};
        else
            ncyc = m_cyc + 64'd1;
        if (doit && csr_idx == 12'hB02)
            nins = {m_ins[63:32], wv};
        else if (doit && csr_idx == 12'hB82)
            nins = {wv, m_ins[31:0] + 32'(instret_ena)};
        else
            nins = m_ins + 64'(instret_ena);
        if (excp_ena) begin
            m_epc = excp_mepc & ~32'h1;
            m_cause = excp_cause;
            m_mpie = m_mie;
            m_mie = 0;
        end else begin
            if (doit && csr_idx == 12'h341) m_epc = wv & ~32'h1;
            if (doit && csr_idx == 12'h342) m_cause = wv;
            if (mret_ena) begin
                m_mie = m_mpie;
                m_mpie = 1;
            end else if (doit && csr_idx == 12'h300) begin
                m_mie = wv[3];
                m_mpie = wv[7];
            end
        end
        if (doit && csr_idx == 12'h304) m_ie = wv & 32'h888;
        if (doit && csr_idx == 12'h305)
            m_tvec = wv[1] ? (wv & ~32'h3) : wv;
        if (doit && csr_idx == 12'h340) m_scr = wv;
        m_ip = (32'(irq_ext) << 11) | (32'(irq_tmr) << 7)
             | (32'(irq_sw) << 3);
        m_cyc = ncyc;
        m_ins = nins;
    endtask

    task automatic cmp_model();
        bit ill;
        bit req;
        ill = ((csr_rd_en || csr_wr_en) && !m_legal(csr_idx))
           || (csr_wr_en && csr_op != 2'd0 && m_ro(csr_idx));
        req = m_mie && (m_pend() != 0);
        chk("rd_dat", csr_read_dat, m_read(csr_idx));
        chk("illegal", csr_illegal, ill);
        chk("irq_req", irq_req, req);
        if (req) chk("irq_cause", irq_cause, m_irq_cause());
        chk("trap_pc", trap_pc, m_trap());
        chk("mepc", csr_mepc, m_epc);
        chk("mtvec", csr_mtvec, m_tvec);
    endtask

    task automatic settle();
        @(negedge clk);
        cmp_model();
    endtask

    task automatic edge_();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic step();
        settle();
        edge_();
    endtask

    task automatic peek(string tag, logic [11:0] a, logic [31:0] e);
        csr_idx = a;
        #1;
        chk(tag, csr_read_dat, e);
    endtask

    task automatic idle();
        csr_rd_en = 0; csr_wr_en = 0; csr_op = 0;
        csr_idx = 12'h300; csr_write_dat = 0;
        excp_ena = 0; mret_ena = 0; instret_ena = 0;
        excp_mepc = 0; excp_cause = 0;
    endtask

    task automatic csrw(logic [11:0] a, logic [1:0] op,
                        logic [31:0] d);
        csr_wr_en = 1; csr_rd_en = 1; csr_op = op;
        csr_idx = a; csr_write_dat = d;
    endtask

    initial begin
        idle();
        irq_sw = 0; irq_tmr = 0; irq_ext = 0;
        reset = 1;
        edge_();
        edge_();
        reset = 0;

        csr_rd_en = 1;
        csr_idx = 12'h305;
        settle();
        chk("rst_mtvec", csr_read_dat, TVEC_RST);
        chk("rst_mepc", csr_mepc, 0);
        chk("rst_irq", irq_req, 0);
        peek("rst_mstatus", 12'h300, 32'h1800);
        peek("mhartid", 12'hF14, 32'(HID));
        chk("hart_legal", csr_illegal, 0);
        peek("unimpl_dat", 12'h7C0, 32'h0);
        chk("unimpl_ill", csr_illegal, 1);
        edge_();

        csrw(12'h304, 2'd1, 32'h80);
        step();
        csrw(12'h300, 2'd2, 32'h8);
        step();
        idle();
        irq_tmr = 1;
        settle();
        chk("irq_same_cyc", irq_req, 0);
        edge_();
        settle();
        chk("irq_tmr_req", irq_req, 1);
        chk("irq_tmr_cause", irq_cause, 32'h8000_0007);
        edge_();
        irq_ext = 1;
        csrw(12'h304, 2'd2, 32'h800);
        step();
        idle();
        settle();
        chk("irq_ext_cause", irq_cause, 32'h8000_000B);
        edge_();
        irq_tmr = 0; irq_ext = 0;

        csrw(12'h305, 2'd1, 32'h0000_1001);
        step();
        idle();
        excp_ena = 1;
        excp_cause = 32'h8000_0007;
        excp_mepc = 32'h2003;
        settle();
        chk("vec_trap_pc", trap_pc, 32'h101C);
        edge_();
        idle();
        settle();
        chk("trap_mepc", csr_mepc, 32'h2002);
        peek("trap_mstatus", 12'h300, 32'h1880);
        edge_();
        mret_ena = 1;
        step();
        idle();
        settle();
        peek("mret_mstatus", 12'h300, 32'h1888);
        edge_();

        excp_ena = 1;
        excp_mepc = 32'h3000;
        csrw(12'h341, 2'd1, 32'h4000);
        step();
        idle();
        settle();
        chk("excp_over_wr", csr_mepc, 32'h3000);
        edge_();
        csrw(12'h300, 2'd2, 32'h8);
        step();
        idle();
        settle();
        peek("mstatus_set", 12'h300, 32'h1888);
        edge_();
        csrw(12'h300, 2'd3, 32'h8);
        step();
        idle();
        settle();
        peek("mstatus_clr", 12'h300, 32'h1880);
        edge_();

        csrw(12'hB00, 2'd1, 32'hFFFF_FFFF);
        step();
        idle();
        step();
        step();
        settle();
        peek("mcycleh_carry", 12'hB80, 32'h1);
        peek("mcycle_wrap", 12'hB00, 32'h1);
        edge_();
        csrw(12'hB02, 2'd1, 32'h55);
        instret_ena = 1;
        step();
        idle();
        settle();
        peek("minstret_hold", 12'hB02, 32'h55);
        edge_();

        csrw(12'h344, 2'd1, 32'h88);
        settle();
        chk("mip_wr_ill", csr_illegal, 1);
        edge_();
        idle();
        settle();
        peek("mip_unchg", 12'h344, 32'h0);
        edge_();
        excp_ena = 1;
        excp_mepc = 32'h5000;
        reset = 1;
        step();
        reset = 0;
        idle();
        settle();
        chk("rst_over_excp", csr_mepc, 32'h0);
        edge_();

        for (int n = 0; n < 600; n++) begin
            csr_idx = idx_tab[$urandom_range(13)];
            csr_op = 2'($urandom_range(3));
            csr_rd_en = 1'($urandom_range(1));
            csr_wr_en = ($urandom_range(2) != 0);
            csr_write_dat = ($urandom_range(3) == 0)
                ? 32'($urandom_range(15)) : $urandom;
            if (csr_idx == 12'h300 && $urandom_range(1) == 1)
                csr_write_dat = 32'h88;
            if (csr_idx == 12'h304 && $urandom_range(1) == 1)
                csr_write_dat = 32'h888;
            irq_sw = 1'($urandom_range(1));
            irq_tmr = 1'($urandom_range(1));
            irq_ext = ($urandom_range(3) == 0);
            excp_ena = ($urandom_range(7) == 0);
            mret_ena = ($urandom_range(7) == 0);
            instret_ena = 1'($urandom_range(1));
            excp_mepc = $urandom;
            excp_cause = $urandom;
            reset = ($urandom_range(99) == 0);
            step();
        end
        reset = 0;
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
